// File: rtl/spi_slave_burst_fsm.sv
// SPI slave protocol FSM: deserialises {cmd,data} frames from MOSI and
// serialises read words onto MISO, with optional burst reads and abort detection.
module spi_slave_burst_fsm #(
    parameter int DATA_W = 8,
    parameter bit BURST  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              valid_MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              sready,
    output logic              frame_err
);

    localparam int FRAME_W = DATA_W + 2;
    localparam int CW      = 6;
    localparam logic [CW-1:0] LAST_RX = CW'(FRAME_W - 1);
    localparam logic [CW-1:0] LAST_TX = CW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, HOLD
    } state_t;

    state_t             state, state_d;
    logic [CW-1:0]      cnt, cnt_d;
    logic [FRAME_W-2:0] rx_sh, rx_sh_d;
    logic [DATA_W-1:0]  tx_sh, tx_sh_d;
    logic               rd_addr_seen, seen_d;
    logic               miso_d, vmiso_d, rx_valid_d, sready_d, ferr_d;
    logic [FRAME_W-1:0] rx_data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rx_sh        <= '0;
            tx_sh        <= '0;
            rd_addr_seen <= 1'b0;
            MISO         <= 1'b0;
            valid_MISO   <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            sready       <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            rx_sh        <= rx_sh_d;
            tx_sh        <= tx_sh_d;
            rd_addr_seen <= seen_d;
            MISO         <= miso_d;
            valid_MISO   <= vmiso_d;
            rx_valid     <= rx_valid_d;
            rx_data      <= rx_data_d;
            sready       <= sready_d;
            frame_err    <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        rx_sh_d    = rx_sh;
        tx_sh_d    = tx_sh;
        seen_d     = rd_addr_seen;
        miso_d     = MISO;
        vmiso_d    = valid_MISO;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data;
        sready_d   = sready;
        ferr_d     = 1'b0;
        if (ss_n) begin
            // Deselect always wins; only mid-frame or mid-word states flag an error.
            state_d  = IDLE;
            cnt_d    = '0;
            sready_d = 1'b0;
            vmiso_d  = 1'b0;
            miso_d   = 1'b0;
            ferr_d   = (state inside {CHK_CMD, WRITE, READ_ADD, READ_DATA, SEND});
        end else begin
            unique case (state)
                IDLE: begin
                    state_d = CHK_CMD;
                    cnt_d   = '0;
                end
                CHK_CMD: begin
                    rx_sh_d = {rx_sh[FRAME_W-3:0], MOSI};
                    cnt_d   = CW'(1);
                    if (!MOSI)
                        state_d = WRITE;
                    else if (rd_addr_seen)
                        state_d = READ_DATA;
                    else
                        state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    rx_sh_d = {rx_sh[FRAME_W-3:0], MOSI};
                    cnt_d   = cnt + 1'b1;
                    if (cnt == LAST_RX) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = {rx_sh, MOSI};
                        cnt_d      = '0;
                        if (state == READ_DATA) begin
                            state_d  = WAIT_TX;
                            sready_d = 1'b1;
                            seen_d   = 1'b0;
                        end else begin
                            state_d = HOLD;
                            if (state == READ_ADD)
                                seen_d = 1'b1;
                        end
                    end
                end
                WAIT_TX: begin
                    if (tx_valid) begin
                        tx_sh_d  = {tx_data[DATA_W-2:0], 1'b0};
                        miso_d   = tx_data[DATA_W-1];
                        vmiso_d  = 1'b1;
                        sready_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = SEND;
                    end
                end
                SEND: begin
                    if (cnt == LAST_TX) begin
                        vmiso_d = 1'b0;
                        miso_d  = 1'b0;
                        cnt_d   = '0;
                        if (BURST) begin
                            state_d  = WAIT_TX;
                            sready_d = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        miso_d  = tx_sh[DATA_W-1];
                        tx_sh_d = {tx_sh[DATA_W-2:0], 1'b0};
                        cnt_d   = cnt + 1'b1;
                    end
                end
                HOLD: begin
                    state_d = HOLD;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_burst_fsm.sv
// Scoreboard bench for spi_slave_burst_fsm: an 8-bit burst instance and a
// 16-bit single-word instance, each with its own output monitor.
module tb_spi_slave_burst_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  ss   = 2'b11;
    logic [1:0]  mosi = 2'b00;
    logic [1:0]  txv  = 2'b00;
    logic [7:0]  txd8 = '0;
    logic [15:0] txd16 = '0;

    logic miso8, vm8, rxv8, sr8, fe8;
    logic [9:0] rxd8;
    logic miso16, vm16, rxv16, sr16, fe16;
    logic [17:0] rxd16;

    int n_vec = 0;
    int n_err = 0;
    int exp_fe8 = 0;
    int exp_fe16 = 0;
    logic [9:0]  q_rx8[$];
    logic [7:0]  q_w8[$];
    logic [17:0] q_rx16[$];
    logic [15:0] q_w16[$];

    spi_slave_burst_fsm #(.DATA_W(8), .BURST(1'b1)) u8 (
        .clk(clk), .rst(rst), .ss_n(ss[0]), .MOSI(mosi[0]),
        .tx_valid(txv[0]), .tx_data(txd8), .MISO(miso8),
        .valid_MISO(vm8), .rx_valid(rxv8), .rx_data(rxd8),
        .sready(sr8), .frame_err(fe8)
    );

    spi_slave_burst_fsm #(.DATA_W(16), .BURST(1'b0)) u16 (
        .clk(clk), .rst(rst), .ss_n(ss[1]), .MOSI(mosi[1]),
        .tx_valid(txv[1]), .tx_data(txd16), .MISO(miso16),
        .valid_MISO(vm16), .rx_valid(rxv16), .rx_data(rxd16),
        .sready(sr16), .frame_err(fe16)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic sr_of(input int s);
        return (s == 0) ? sr8 : sr16;
    endfunction

    task automatic frame(input int s, input logic [33:0] f, input int fw, input int nb);
        @(negedge clk);
        ss[s] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            mosi[s] = f[fw-1-i];
        end
    endtask

    task automatic release_ss(input int s);
        @(negedge clk);
        ss[s] = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_sr(input int s);
        int t = 0;
        while (!sr_of(s) && t < 64) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("sready_wait_%0d", s), 32'(sr_of(s)), 32'd1);
    endtask

    task automatic supply(input int s, input logic [15:0] d, input bit expect_word);
        wait_sr(s);
        txv[s] = 1'b1;
        if (s == 0) begin
            txd8 = d[7:0];
            if (expect_word) q_w8.push_back(d[7:0]);
        end else begin
            txd16 = d;
            if (expect_word) q_w16.push_back(d);
        end
        @(negedge clk);
        txv[s] = 1'b0;
    endtask

    initial begin : mon8
        logic [7:0] w;
        int bc;
        w = '0;
        bc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bc = 0;
            end else begin
                if (rxv8) begin
                    if (q_rx8.size() == 0) chk("rx8_unexpected", 32'(rxv8), 32'd0);
                    else chk("rx_data8", 32'(rxd8), 32'(q_rx8.pop_front()));
                end
                if (fe8) begin
                    if (exp_fe8 == 0) chk("frame_err8_unexpected", 32'(fe8), 32'd0);
                    else begin
                        exp_fe8--;
                        chk("frame_err8", 32'(fe8), 32'd1);
                    end
                end
                if (vm8) begin
                    w = {w[6:0], miso8};
                    bc++;
                    if (bc == 8) begin
                        if (q_w8.size() == 0) chk("word8_unexpected", 32'(vm8), 32'd0);
                        else chk("miso_word8", 32'(w), 32'(q_w8.pop_front()));
                        bc = 0;
                    end
                end else if (bc != 0) begin
                    chk("miso8_short", 32'(bc), 32'd8);
                    bc = 0;
                end
            end
        end
    end

    initial begin : mon16
        logic [15:0] w;
        int bc;
        w = '0;
        bc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bc = 0;
            end else begin
                if (rxv16) begin
                    if (q_rx16.size() == 0) chk("rx16_unexpected", 32'(rxv16), 32'd0);
                    else chk("rx_data16", 32'(rxd16), 32'(q_rx16.pop_front()));
                end
                if (fe16) begin
                    if (exp_fe16 == 0) chk("frame_err16_unexpected", 32'(fe16), 32'd0);
                    else begin
                        exp_fe16--;
                        chk("frame_err16", 32'(fe16), 32'd1);
                    end
                end
                if (vm16) begin
                    w = {w[14:0], miso16};
                    bc++;
                    if (bc == 16) begin
                        if (q_w16.size() == 0) chk("word16_unexpected", 32'(vm16), 32'd0);
                        else chk("miso_word16", 32'(w), 32'(q_w16.pop_front()));
                        bc = 0;
                    end
                end else if (bc != 0) begin
                    chk("miso16_short", 32'(bc), 32'd16);
                    bc = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_miso8", 32'(miso8), 0);
        chk("rst_vmiso8", 32'(vm8), 0);
        chk("rst_rxv8", 32'(rxv8), 0);
        chk("rst_rxd8", 32'(rxd8), 0);
        chk("rst_sready8", 32'(sr8), 0);
        chk("rst_ferr8", 32'(fe8), 0);
        chk("rst_vmiso16", 32'(vm16), 0);
        chk("rst_rxd16", 32'(rxd16), 0);
        chk("rst_sready16", 32'(sr16), 0);
        @(negedge clk);
        rst = 1'b0;

        // 8-bit write frame
        q_rx8.push_back(10'h0A5);
        frame(0, 34'h0A5, 10, 10);
        @(negedge clk);
        chk("write_sready8", 32'(sr8), 0);
        release_ss(0);

        // abort after 5 bits, then a clean write
        exp_fe8++;
        frame(0, 34'h0A5, 10, 5);
        release_ss(0);
        q_rx8.push_back(10'h155);
        frame(0, 34'h155, 10, 10);
        release_ss(0);

        // read address then read data, burst of three words
        q_rx8.push_back(10'h203);
        frame(0, 34'h203, 10, 10);
        @(negedge clk);
        chk("addr_sready8", 32'(sr8), 0);
        release_ss(0);
        q_rx8.push_back(10'h37E);
        frame(0, 34'h37E, 10, 10);
        @(negedge clk);
        chk("data_sready8", 32'(sr8), 1);
        supply(0, 16'h00C3, 1'b1);
        supply(0, 16'h005A, 1'b1);
        supply(0, 16'h00FF, 1'b1);

        // tx_valid coincident with deselect: no capture, no error
        wait_sr(0);
        txv[0] = 1'b1;
        txd8 = 8'hAA;
        ss[0] = 1'b1;
        @(negedge clk);
        txv[0] = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_tx_sready8", 32'(sr8), 0);
        chk("abort_tx_vmiso8", 32'(vm8), 0);

        // deselect on the last-bit edge
        exp_fe8++;
        frame(0, 34'h0A5, 10, 9);
        release_ss(0);

        // 16-bit instance: address, data, single word
        q_rx16.push_back(18'h21234);
        frame(1, 34'h21234, 18, 18);
        release_ss(1);
        q_rx16.push_back(18'h30000);
        frame(1, 34'h30000, 18, 18);
        @(negedge clk);
        chk("data_sready16", 32'(sr16), 1);
        supply(1, 16'hBEEF, 1'b1);
        repeat (24) @(negedge clk);
        chk("noburst_sready16", 32'(sr16), 0);
        chk("noburst_words16", 32'(q_w16.size()), 0);
        release_ss(1);

        // reset in the middle of a word
        q_rx16.push_back(18'h20001);
        frame(1, 34'h20001, 18, 18);
        release_ss(1);
        q_rx16.push_back(18'h30002);
        frame(1, 34'h30002, 18, 18);
        supply(1, 16'h1234, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ss[1] = 1'b1;
        #1;
        chk("rst_mid_vmiso16", 32'(vm16), 0);
        chk("rst_mid_miso16", 32'(miso16), 0);
        chk("rst_mid_rxd16", 32'(rxd16), 0);
        chk("rst_mid_sready16", 32'(sr16), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset after an address frame forgets it
        q_rx16.push_back(18'h2ABCD);
        frame(1, 34'h2ABCD, 18, 18);
        @(negedge clk);
        rst = 1'b1;
        ss[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q_rx16.push_back(18'h3FFFF);
        frame(1, 34'h3FFFF, 18, 18);
        @(negedge clk);
        chk("post_rst_read_is_addr16", 32'(sr16), 0);
        release_ss(1);

        repeat (4) @(negedge clk);
        chk("left_rx8", 32'(q_rx8.size()), 0);
        chk("left_w8", 32'(q_w8.size()), 0);
        chk("left_fe8", 32'(exp_fe8), 0);
        chk("left_rx16", 32'(q_rx16.size()), 0);
        chk("left_w16", 32'(q_w16.size()), 0);
        chk("left_fe16", 32'(exp_fe16), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_burst_fsm.md
# spi_slave_burst_fsm

Parametrised SPI slave protocol FSM: the next generation of the team's fixed 8-bit SPI slave controller. Deserialises command+data frames from MOSI into `rx_data` for the RAM/register side, and serialises read data from `tx_data` onto MISO. It adds a configurable data width, optional burst reads and abort detection. It sits between the SPI pins (`clk` is the SPI clock) and the memory wrapper.

## Interface
- `DATA_W`, 8: data field width; frame width `FRAME_W = DATA_W + 2`; legal range 2..32.
- `BURST`, 1: 1 = read-data streams successive words while `ss_n` stays low; 0 = one word per frame.
- `clk` in 1: SPI clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ss_n` in 1: slave select, active low.
- `MOSI` in 1: serial in, MSB first.
- `tx_valid` in 1: `tx_data` valid; accepted only while `sready` = 1.
- `tx_data` in DATA_W: read word to serialise.
- `MISO` out 1: serial out, MSB first, registered.
- `valid_MISO` out 1: high on every cycle `MISO` carries a data bit.
- `rx_valid` out 1: one-cycle pulse, `rx_data` holds a complete frame.
- `rx_data` out FRAME_W: `{cmd[1:0], data[DATA_W-1:0]}`.
- `sready` out 1: slave is waiting for a read word.
- `frame_err` out 1: one-cycle pulse, `ss_n` rose mid-frame or mid-transmit.

## Operation
- Reset values: all outputs 0; state IDLE; bit counter 0; internal `rd_addr_seen` 0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, HOLD.
- IDLE: `ss_n` = 0 -> CHK_CMD. No bit is consumed on this edge.
- CHK_CMD: samples MOSI as frame bit FRAME_W-1.
  - 0 -> WRITE.
  - 1 and `rd_addr_seen` = 0 -> READ_ADD.
  - 1 and `rd_addr_seen` = 1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift in the remaining FRAME_W-1 bits.
  - On the last bit: `rx_data` <= full frame and `rx_valid` pulses.
  - WRITE, READ_ADD -> HOLD. READ_ADD sets `rd_addr_seen`.
  - READ_DATA -> WAIT_TX with `sready` = 1 and clears `rd_addr_seen`.
- Command bit 0 comes from MOSI, not from `rd_addr_seen`. `rx_data` always holds the bits actually received.
- WAIT_TX: stays until `tx_valid` = 1.
  - On that edge: capture `tx_data`, `sready` <= 0, `MISO` <= bit DATA_W-1, `valid_MISO` <= 1 -> SEND.
- SEND: drives bits DATA_W-2..0 on successive edges. After the last bit, `valid_MISO` <= 0 and `MISO` <= 0.
  - `BURST` = 1 -> WAIT_TX, `sready` <= 1 on the same edge.
  - `BURST` = 0 -> HOLD.
- HOLD: waits for `ss_n` = 1 -> IDLE. MOSI is ignored.
- `ss_n` = 1 in any state -> IDLE on the next edge.
  - `sready`, `valid_MISO` and `MISO` are cleared on that edge.
  - `frame_err` pulses if the state was CHK_CMD, WRITE, READ_ADD, READ_DATA with a partial count, or SEND.
  - A partial frame is discarded: no `rx_valid`, `rx_data` and `rd_addr_seen` unchanged.
- `tx_valid` outside WAIT_TX is ignored.

## Timing
- Edge 0 samples `ss_n` low; frame bits are sampled on edges 1..FRAME_W.
- `rx_valid` and `rx_data` update on edge FRAME_W; `rx_valid` is high for exactly one cycle.
- `sready` rises on edge FRAME_W of a read-data frame.
- Read latency: accept edge T -> MISO MSB is valid in cycle T..T+1; the LSB is valid after edge T+DATA_W-1; `valid_MISO` falls on edge T+DATA_W.
- Burst gap: minimum 1 cycle with `valid_MISO` = 0 between words, when `tx_valid` is held high.
- Simultaneous events:
  - `ss_n` rising together with `tx_valid` in WAIT_TX: abort wins, no capture, no `frame_err` (WAIT_TX is a clean boundary).
  - `ss_n` rising on the edge that samples the last frame bit: treated as abort, `frame_err` = 1, no `rx_valid`.
- Asynchronous `rst` mid-frame: all outputs are 0 immediately and `rd_addr_seen` is cleared.

## Test plan
- Write (DATA_W=8): `ss_n` low, shift 00_1010_0101 -> `rx_valid` pulse on edge 10, `rx_data` = 10'h0A5, `sready` stays 0.
- Read sequence: frame 10_0000_0011, `ss_n` high, frame 11_xxxx_xxxx.
  - `sready` = 1 on edge 10 of the second frame.
  - `tx_valid` with 8'hC3 -> MISO 1,1,0,0,0,0,1,1 with `valid_MISO` high 8 cycles.
- Burst (BURST=1): after the first word, hold `ss_n` low and supply 8'h5A then 8'hFF.
  - Two further words are serialised, each with a 1-cycle gap and `sready` re-asserted between them.
  - Repeat with BURST=0: `sready` stays 0 after the first word.
- Abort: raise `ss_n` after 5 bits of a write -> `frame_err` 1 cycle, no `rx_valid`, next frame decodes normally.
- Parametric: DATA_W=16, read-data frame with 16'hBEEF -> 16 MISO bits MSB first, `rx_data` 18 bits; assert `rst` mid-SEND -> all outputs 0 immediately, and the next 1x frame decodes as READ_ADD.
